bank_isu_iq_age: RTL and testbench
==================================

Name: bank_isu_iq_age

Overview:
- Parametrised next-generation bank issue queue, between the bank tag/lookup stage and the SRAM controller.
- Buffers up to DEPTH requests and holds miss or inflight requests until the BIU linefill response for their line returns.
- Issues the oldest eligible entry each cycle.
- New over the previous generation: configurable field widths, same-line in-order hazard blocking, enqueue-cycle wakeup bypass, and an occupancy output.

Parameters:
PTR_WIDTH, 4, log2 of queue depth; DEPTH = 2^PTR_WIDTH
LINE_W, 6, cacheline (set/way) identifier width; also linefill buffer address width
CH_W, 2, channel id width
ROB_W, 3, xbar ROB id width
PAYLOAD_W, 16, opaque sideband (wbuffer id, offset, line state) carried to SRAM controller

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  1  enqueue request
req_allowIn_o  out  1  queue can accept; enqueue fires when req_valid_i & req_allowIn_o
req_need_linefill_i  in  1  request missed; needs linefill data
req_inflight_i  in  1  line hit but its linefill is still outstanding
req_opcode_i  in  2  bit0 = write, bit1 = evict
req_line_id_i  in  LINE_W  target line
req_ch_id_i  in  CH_W  source channel
req_rob_id_i  in  ROB_W  xbar ROB id
req_payload_i  in  PAYLOAD_W  sideband
biu_isu_rvalid_i  in  1  linefill response valid
biu_isu_rid_i  in  LINE_W  line id of returned linefill
iq_sc_valid_o  out  1  an eligible entry is presented
iq_sc_ready_i  in  1  SRAM controller accepts
iq_sc_opcode_o  out  3  0 write, 1 read, 2 read+linefill, 3 writeback; bit2 = 0
iq_sc_line_id_o  out  LINE_W  selected entry line id
iq_sc_ch_id_o  out  CH_W  selected channel
iq_sc_rob_id_o  out  ROB_W  selected ROB id
iq_sc_payload_o  out  PAYLOAD_W  selected sideband
iq_linefill_buffer_raddr_o  out  LINE_W  equals iq_sc_line_id_o
iq_occupancy_o  out  PTR_WIDTH+1  allocated slots, from bottom_ptr up to write_ptr

Behaviour:
Reset (rst_i high at a clock edge):
- valid, ready, write_ptr, bottom_ptr and count all go to 0.
- Outputs after reset: req_allowIn_o=1, iq_sc_valid_o=0, iq_occupancy_o=0.
- Payload arrays are not reset. Data outputs are don't-care while iq_sc_valid_o=0.
- Reset asserted mid-operation discards all entries; no issue occurs in the reset cycle's successor.

Enqueue:
- req_allowIn_o = (count != DEPTH), derived from registered count only.
- A full queue refuses enqueue even in a cycle where an issue or retire happens.
- On fire: write slot write_ptr, set valid, write_ptr += 1 (mod DEPTH, natural wrap).
- Enqueued ready = ~(need_linefill | inflight) | (biu_isu_rvalid_i & biu_isu_rid_i == req_line_id_i). The last term is the same-cycle bypass.

Wakeup:
- Every cycle biu_isu_rvalid_i is high, set ready on all valid entries whose line_id equals biu_isu_rid_i.
- Already-ready entries are unaffected.

Eligibility:
- An entry is eligible if it is valid, ready, and no older valid entry has the same line_id.
- Age is (index - bottom_ptr) mod DEPTH; smaller is older.
- An older same-line entry blocks even when that older entry is itself ready.

Select and issue:
- Select the eligible entry with the smallest age.
- iq_sc_valid_o = any eligible. All iq_sc_* outputs are combinational from registered state.
- On iq_sc_valid_o & iq_sc_ready_i, clear the selected entry's valid at the clock edge.
- Presented entry may change between cycles while ready is low, e.g. when an older entry wakes up; there is no stickiness requirement.

Opcode:
- evict → 3
- else need_linefill → 2
- else write → 0
- else → 1
- The stored need_linefill flag is used, not ready.

Retire:
- When count != 0 and valid[bottom_ptr] == 0, bottom_ptr += 1.
- At most one retire per cycle.
- Holes behind a non-issued head stay allocated.

Count and latency:
- Count next value: +1 on enqueue only, -1 on retire only, unchanged on both or neither.
- iq_occupancy_o = count.
- Minimum latency: enqueue at cycle t with ready=1 → iq_sc_valid_o at t+1.
- Wakeup at t → issue possible at t+1.

Test Plan:
- Reset, then enqueue 3 hit reads (line 5, 6, 7) with ready held 1 → issues in order 5, 6, 7 on cycles t+1..t+3, opcode 1; occupancy peaks ≤3 and returns to 0 two cycles after the last issue.
- Enqueue a miss on line 9 (need_linefill=1), then a hit read on line 4; rvalid with rid 9 three cycles later → line 4 issues first; line 9 issues the cycle after rvalid with opcode 2.
- Enqueue a miss write on line 3, then an inflight read on line 3; assert rvalid rid 3 → write (opcode 2) issues first; read (opcode 1) is not presented until the write's valid clears.
- Enqueue a miss on line 12 in the same cycle as rvalid rid 12 → iq_sc_valid_o=1 next cycle for that entry (bypass).
- PTR_WIDTH=2: fill 4 entries with iq_sc_ready_i=0 → req_allowIn_o=0 and occupancy=4; then drain with ready=1 while enqueueing → write_ptr wraps 3→0 and no entry is lost or duplicated.
- Assert rst_i with 2 valid ready entries and iq_sc_ready_i=1 → next cycle iq_sc_valid_o=0, occupancy=0, req_allowIn_o=1.

Source files
------------

// File: rtl/bank_isu_iq_age_if.sv
// ---------------------------------------------------------------------------
// bank_isu_iq_age_if
// Bundles the request, linefill-response and SRAM-controller issue signals
// of the bank issue queue.
//   master : the surrounding pipeline (tag/lookup stage, BIU, SRAM controller)
//   slave  : the issue queue itself
// Signals:
//   req_*                    enqueue request from the tag/lookup stage
//   biu_isu_rvalid/_rid      linefill response wakeup
//   iq_sc_*                  selected entry presented to the SRAM controller
//   iq_linefill_buffer_raddr linefill buffer read address (selected line)
//   iq_occupancy             number of allocated queue slots
// ---------------------------------------------------------------------------
interface bank_isu_iq_age_if #(
   parameter int PTR_WIDTH = 4,
   parameter int LINE_W    = 6,
   parameter int CH_W      = 2,
   parameter int ROB_W     = 3,
   parameter int PAYLOAD_W = 16
);
   logic                 req_valid;
   logic                 req_allowIn;
   logic                 req_need_linefill;
   logic                 req_inflight;
   logic [1:0]           req_opcode;
   logic [LINE_W-1:0]    req_line_id;
   logic [CH_W-1:0]      req_ch_id;
   logic [ROB_W-1:0]     req_rob_id;
   logic [PAYLOAD_W-1:0] req_payload;

   logic                 biu_isu_rvalid;
   logic [LINE_W-1:0]    biu_isu_rid;

   logic                 iq_sc_valid;
   logic                 iq_sc_ready;
   logic [2:0]           iq_sc_opcode;
   logic [LINE_W-1:0]    iq_sc_line_id;
   logic [CH_W-1:0]      iq_sc_ch_id;
   logic [ROB_W-1:0]     iq_sc_rob_id;
   logic [PAYLOAD_W-1:0] iq_sc_payload;
   logic [LINE_W-1:0]    iq_linefill_buffer_raddr;
   logic [PTR_WIDTH:0]   iq_occupancy;

   modport master (
      output req_valid, req_need_linefill, req_inflight, req_opcode,
             req_line_id, req_ch_id, req_rob_id, req_payload,
      input  req_allowIn,
      output biu_isu_rvalid, biu_isu_rid,
      output iq_sc_ready,
      input  iq_sc_valid, iq_sc_opcode, iq_sc_line_id, iq_sc_ch_id,
             iq_sc_rob_id, iq_sc_payload, iq_linefill_buffer_raddr,
             iq_occupancy
   );

   modport slave (
      input  req_valid, req_need_linefill, req_inflight, req_opcode,
             req_line_id, req_ch_id, req_rob_id, req_payload,
      output req_allowIn,
      input  biu_isu_rvalid, biu_isu_rid,
      input  iq_sc_ready,
      output iq_sc_valid, iq_sc_opcode, iq_sc_line_id, iq_sc_ch_id,
             iq_sc_rob_id, iq_sc_payload, iq_linefill_buffer_raddr,
             iq_occupancy
   );
endinterface

// File: rtl/bank_isu_iq_age.sv
// ---------------------------------------------------------------------------
// bank_isu_iq_age
// Age-ordered bank issue queue between the tag/lookup stage and the SRAM
// controller. Requests that missed, or hit a line whose linefill is still
// outstanding, wait until the BIU returns that line. Every cycle the oldest
// eligible entry (valid, ready, no older valid entry on the same line) is
// presented to the SRAM controller.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : bank_isu_iq_age_if.slave (request, wakeup, issue, occupancy)
// ---------------------------------------------------------------------------
module bank_isu_iq_age #(
   parameter int PTR_WIDTH = 4,
   parameter int LINE_W    = 6,
   parameter int CH_W      = 2,
   parameter int ROB_W     = 3,
   parameter int PAYLOAD_W = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   bank_isu_iq_age_if.slave bus
);
   localparam int DEPTH = 1 << PTR_WIDTH;

   typedef logic [PTR_WIDTH-1:0] ptr_t;

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     ready_q, ready_d;
   logic [DEPTH-1:0]     needLf_q;
   logic [1:0]           opcode_q  [DEPTH];
   logic [LINE_W-1:0]    lineId_q  [DEPTH];
   logic [CH_W-1:0]      chId_q    [DEPTH];
   logic [ROB_W-1:0]     robId_q   [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];

   ptr_t                 writePtr_q, writePtr_d;
   ptr_t                 bottomPtr_q, bottomPtr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;

   logic                 allowIn;
   logic                 enqFire;
   logic                 enqReady;
   logic                 issueFire;
   logic                 retire;
   logic [DEPTH-1:0]     eligible;
   logic                 selValid;
   ptr_t                 selIdx;
   logic [2:0]           selOpcode;

   assign allowIn   = (count_q != (PTR_WIDTH+1)'(DEPTH));
   assign enqFire   = bus.req_valid & allowIn;
   assign issueFire = selValid & bus.iq_sc_ready;
   assign retire    = (count_q != '0) & ~valid_q[bottomPtr_q];

   // A new entry is ready unless it waits for a linefill, but a response for
   // its own line arriving in the enqueue cycle wakes it immediately, since
   // the wakeup loop below only sees entries that are already stored.
   assign enqReady = ~(bus.req_need_linefill | bus.req_inflight)
                   | (bus.biu_isu_rvalid & (bus.biu_isu_rid == bus.req_line_id));

   // An entry is eligible when it is valid and ready and no older valid entry
   // targets the same line. Ages are measured from bottomPtr_q so ordering
   // stays correct across pointer wrap. An older same-line entry blocks even
   // when it is ready itself, keeping same-line requests in order.
   always_comb begin
      ptr_t ageI;
      ptr_t ageJ;
      logic blocked;
      eligible = '0;
      ageI     = '0;
      ageJ     = '0;
      blocked  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ageI    = PTR_WIDTH'(i) - bottomPtr_q;
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            ageJ = PTR_WIDTH'(j) - bottomPtr_q;
            if (valid_q[j] && (lineId_q[j] == lineId_q[i]) && (ageJ < ageI)) begin
               blocked = 1'b1;
            end
         end
         eligible[i] = valid_q[i] & ready_q[i] & ~blocked;
      end
   end

   // Scan from the oldest slot upward and take the first eligible entry.
   always_comb begin
      ptr_t idx;
      selValid = 1'b0;
      selIdx   = '0;
      idx      = '0;
      for (int a = 0; a < DEPTH; a++) begin
         idx = bottomPtr_q + PTR_WIDTH'(a);
         if (!selValid && eligible[idx]) begin
            selValid = 1'b1;
            selIdx   = idx;
         end
      end
   end

   // SRAM controller opcode: evict wins, then linefill (from the stored miss
   // flag, not from ready), then plain write or read.
   always_comb begin
      selOpcode = 3'd1;
      if (opcode_q[selIdx][1]) begin
         selOpcode = 3'd3;
      end else if (needLf_q[selIdx]) begin
         selOpcode = 3'd2;
      end else if (opcode_q[selIdx][0]) begin
         selOpcode = 3'd0;
      end
   end

   assign bus.req_allowIn              = allowIn;
   assign bus.iq_sc_valid              = selValid;
   assign bus.iq_sc_opcode             = selOpcode;
   assign bus.iq_sc_line_id            = lineId_q[selIdx];
   assign bus.iq_sc_ch_id              = chId_q[selIdx];
   assign bus.iq_sc_rob_id             = robId_q[selIdx];
   assign bus.iq_sc_payload            = payload_q[selIdx];
   assign bus.iq_linefill_buffer_raddr = lineId_q[selIdx];
   assign bus.iq_occupancy             = count_q;

   // Next-state for the per-entry flags and the pointers. A linefill response
   // wakes every stored entry on that line; an issue frees the selected slot;
   // an enqueue claims the write slot (always free while not full). Holes left
   // by out-of-order issue stay allocated until the head reaches them.
   always_comb begin
      valid_d = valid_q;
      ready_d = ready_q;
      if (bus.biu_isu_rvalid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (lineId_q[i] == bus.biu_isu_rid)) begin
               ready_d[i] = 1'b1;
            end
         end
      end
      if (issueFire) begin
         valid_d[selIdx] = 1'b0;
      end
      if (enqFire) begin
         valid_d[writePtr_q] = 1'b1;
         ready_d[writePtr_q] = enqReady;
      end
      writePtr_d  = enqFire ? writePtr_q + 1'b1 : writePtr_q;
      bottomPtr_d = retire ? bottomPtr_q + 1'b1 : bottomPtr_q;
      count_d     = count_q;
      if (enqFire && !retire) begin
         count_d = count_q + 1'b1;
      end else if (!enqFire && retire) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state register with synchronous reset; a reset discards every
   // entry so nothing can issue in the following cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         ready_q     <= '0;
         writePtr_q  <= '0;
         bottomPtr_q <= '0;
         count_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         ready_q     <= ready_d;
         writePtr_q  <= writePtr_d;
         bottomPtr_q <= bottomPtr_d;
         count_q     <= count_d;
      end
   end

   // Entry payload storage, written on enqueue only; contents of invalid
   // slots are never observed, so these registers carry no reset.
   always_ff @(posedge clk_i) begin
      if (enqFire) begin
         needLf_q[writePtr_q]  <= bus.req_need_linefill;
         opcode_q[writePtr_q]  <= bus.req_opcode;
         lineId_q[writePtr_q]  <= bus.req_line_id;
         chId_q[writePtr_q]    <= bus.req_ch_id;
         robId_q[writePtr_q]   <= bus.req_rob_id;
         payload_q[writePtr_q] <= bus.req_payload;
      end
   end
endmodule

// File: tb/tb_bank_isu_iq_age.sv
// ---------------------------------------------------------------------------
// tb_bank_isu_iq_age
// Self-checking bench for bank_isu_iq_age built with a 4-entry queue so that
// full and pointer-wrap behaviour is reached quickly. Table-driven vectors
// cover in-order issue and miss wakeup; hand-written sequences cover
// same-line blocking, enqueue bypass, full/wrap and reset.
// ---------------------------------------------------------------------------
module tb_bank_isu_iq_age;
   localparam int PTR_WIDTH = 2;
   localparam int LINE_W    = 6;
   localparam int CH_W      = 2;
   localparam int ROB_W     = 3;
   localparam int PAYLOAD_W = 16;

   typedef struct {
      logic              vld;
      logic              needLf;
      logic              inflight;
      logic [1:0]        op;
      logic [LINE_W-1:0] line;
      logic              rv;
      logic [LINE_W-1:0] rid;
      logic              scRdy;
   } stim_t;

   typedef struct {
      stim_t              s;
      logic               expAllow;
      logic               expValid;
      logic [2:0]         expOp;
      logic [LINE_W-1:0]  expLine;
      int                 expOcc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [LINE_W-1:0] issuedQ[$];
   logic [LINE_W-1:0] expQ[$];
   vec_t vecs[12];

   bank_isu_iq_age_if #(
      .PTR_WIDTH(PTR_WIDTH), .LINE_W(LINE_W), .CH_W(CH_W),
      .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)
   ) bus ();

   bank_isu_iq_age #(
      .PTR_WIDTH(PTR_WIDTH), .LINE_W(LINE_W), .CH_W(CH_W),
      .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Sideband values are derived from the line id so passthrough is checkable.
   function automatic logic [CH_W-1:0] chOf(input logic [LINE_W-1:0] l);
      return l[1:0] ^ 2'b10;
   endfunction

   function automatic logic [ROB_W-1:0] robOf(input logic [LINE_W-1:0] l);
      return l[2:0] + 3'd1;
   endfunction

   function automatic logic [PAYLOAD_W-1:0] payOf(input logic [LINE_W-1:0] l);
      return {l, 2'b01, ~l, 2'b11};
   endfunction

   function automatic stim_t mkStim(input logic vld, input logic needLf,
                                    input logic inflight, input logic [1:0] op,
                                    input logic [LINE_W-1:0] line, input logic rv,
                                    input logic [LINE_W-1:0] rid, input logic scRdy);
      stim_t s;
      s.vld = vld; s.needLf = needLf; s.inflight = inflight; s.op = op;
      s.line = line; s.rv = rv; s.rid = rid; s.scRdy = scRdy;
      return s;
   endfunction

   function automatic stim_t idle(input logic scRdy);
      return mkStim(1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 6'd0, scRdy);
   endfunction

   function automatic vec_t mkVec(input stim_t s, input logic eAllow, input logic eValid,
                                  input logic [2:0] eOp, input logic [LINE_W-1:0] eLine,
                                  input int eOcc);
      vec_t v;
      v.s = s; v.expAllow = eAllow; v.expValid = eValid;
      v.expOp = eOp; v.expLine = eLine; v.expOcc = eOcc;
      return v;
   endfunction

   // Drive one cycle of inputs, log any issue that happens at the edge, and
   // return #1 after the edge so outputs reflect the new registered state.
   task automatic applyStimulus(input stim_t s, input logic rstIn);
      rst                   = rstIn;
      bus.req_valid         = s.vld;
      bus.req_need_linefill = s.needLf;
      bus.req_inflight      = s.inflight;
      bus.req_opcode        = s.op;
      bus.req_line_id       = s.line;
      bus.req_ch_id         = chOf(s.line);
      bus.req_rob_id        = robOf(s.line);
      bus.req_payload       = payOf(s.line);
      bus.biu_isu_rvalid    = s.rv;
      bus.biu_isu_rid       = s.rid;
      bus.iq_sc_ready       = s.scRdy;
      #1;
      if (!rstIn && bus.iq_sc_valid && bus.iq_sc_ready) begin
         issuedQ.push_back(bus.iq_sc_line_id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic expAllow, input logic expValid,
                              input logic [2:0] expOp, input logic [LINE_W-1:0] expLine,
                              input int expOcc);
      checkInt({name, ".allowIn"}, int'(bus.req_allowIn), int'(expAllow));
      checkInt({name, ".scValid"}, int'(bus.iq_sc_valid), int'(expValid));
      checkInt({name, ".occupancy"}, int'(bus.iq_occupancy), expOcc);
      if (expValid) begin
         checkInt({name, ".opcode"}, int'(bus.iq_sc_opcode), int'(expOp));
         checkInt({name, ".line"}, int'(bus.iq_sc_line_id), int'(expLine));
         checkInt({name, ".raddr"}, int'(bus.iq_linefill_buffer_raddr), int'(expLine));
         checkInt({name, ".ch"}, int'(bus.iq_sc_ch_id), int'(chOf(expLine)));
         checkInt({name, ".rob"}, int'(bus.iq_sc_rob_id), int'(robOf(expLine)));
         checkInt({name, ".payload"}, int'(bus.iq_sc_payload), int'(payOf(expLine)));
      end
   endtask

   initial begin
      int nextLine;
      int k;

      // Hit reads on lines 5,6,7 issue in order, then a miss on 9 is passed
      // by a later hit on 4 and issues after its linefill returns.
      vecs[0]  = mkVec(mkStim(1, 0, 0, 2'd0, 6'd5, 0, 6'd0, 1), 1, 1, 3'd1, 6'd5, 1);
      vecs[1]  = mkVec(mkStim(1, 0, 0, 2'd0, 6'd6, 0, 6'd0, 1), 1, 1, 3'd1, 6'd6, 2);
      vecs[2]  = mkVec(mkStim(1, 0, 0, 2'd0, 6'd7, 0, 6'd0, 1), 1, 1, 3'd1, 6'd7, 2);
      vecs[3]  = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 1);
      vecs[4]  = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 0);
      vecs[5]  = mkVec(mkStim(1, 1, 0, 2'd0, 6'd9, 0, 6'd0, 1), 1, 0, 3'd0, 6'd0, 1);
      vecs[6]  = mkVec(mkStim(1, 0, 0, 2'd0, 6'd4, 0, 6'd0, 1), 1, 1, 3'd1, 6'd4, 2);
      vecs[7]  = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 2);
      vecs[8]  = mkVec(mkStim(0, 0, 0, 2'd0, 6'd0, 1, 6'd9, 1), 1, 1, 3'd2, 6'd9, 2);
      vecs[9]  = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 2);
      vecs[10] = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 1);
      vecs[11] = mkVec(idle(1), 1, 0, 3'd0, 6'd0, 0);

      applyStimulus(idle(0), 1'b1);
      applyStimulus(idle(0), 1'b1);
      checkOutput("reset", 1'b1, 1'b0, 3'd0, 6'd0, 0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].s, 1'b0);
         checkOutput($sformatf("vec%0d", i), vecs[i].expAllow, vecs[i].expValid,
                     vecs[i].expOp, vecs[i].expLine, vecs[i].expOcc);
      end

      // Same-line ordering: an inflight read waits behind an older miss write.
      applyStimulus(mkStim(1, 1, 0, 2'b01, 6'd3, 0, 6'd0, 0), 1'b0);
      checkOutput("hazard.enqWrite", 1'b1, 1'b0, 3'd0, 6'd0, 1);
      applyStimulus(mkStim(1, 0, 1, 2'b00, 6'd3, 0, 6'd0, 0), 1'b0);
      checkOutput("hazard.enqRead", 1'b1, 1'b0, 3'd0, 6'd0, 2);
      applyStimulus(mkStim(0, 0, 0, 2'd0, 6'd0, 1, 6'd3, 0), 1'b0);
      checkOutput("hazard.wake", 1'b1, 1'b1, 3'd2, 6'd3, 2);
      applyStimulus(idle(0), 1'b0);
      checkOutput("hazard.hold", 1'b1, 1'b1, 3'd2, 6'd3, 2);
      applyStimulus(idle(1), 1'b0);
      checkOutput("hazard.readNext", 1'b1, 1'b1, 3'd1, 6'd3, 2);
      applyStimulus(idle(1), 1'b0);
      checkOutput("hazard.drained", 1'b1, 1'b0, 3'd0, 6'd0, 1);
      applyStimulus(idle(0), 1'b0);
      checkOutput("hazard.empty", 1'b1, 1'b0, 3'd0, 6'd0, 0);

      // Enqueue-cycle bypass, and a non-matching response that must not wake.
      applyStimulus(mkStim(1, 1, 0, 2'd0, 6'd12, 1, 6'd12, 0), 1'b0);
      checkOutput("bypass.hit", 1'b1, 1'b1, 3'd2, 6'd12, 1);
      applyStimulus(idle(1), 1'b0);
      checkOutput("bypass.issued", 1'b1, 1'b0, 3'd0, 6'd0, 1);
      applyStimulus(mkStim(1, 1, 0, 2'd0, 6'd20, 1, 6'd21, 0), 1'b0);
      checkOutput("bypass.otherRid", 1'b1, 1'b0, 3'd0, 6'd0, 1);
      applyStimulus(mkStim(0, 0, 0, 2'd0, 6'd0, 1, 6'd20, 0), 1'b0);
      checkOutput("bypass.lateWake", 1'b1, 1'b1, 3'd2, 6'd20, 1);
      applyStimulus(idle(1), 1'b0);
      checkOutput("bypass.issued2", 1'b1, 1'b0, 3'd0, 6'd0, 1);
      applyStimulus(idle(0), 1'b0);
      checkOutput("bypass.empty", 1'b1, 1'b0, 3'd0, 6'd0, 0);

      // Fill all four slots while the controller stalls, then drain while
      // enqueueing across the pointer wrap; issue order must match enqueue.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mkStim(1, 0, 0, 2'd0, 6'(30 + i), 0, 6'd0, 0), 1'b0);
         checkOutput($sformatf("fill%0d", i), (i != 3), 1'b1, 3'd1, 6'd30, i + 1);
      end
      issuedQ.delete();
      expQ = '{6'd30, 6'd31, 6'd32, 6'd33};
      applyStimulus(mkStim(1, 0, 0, 2'd0, 6'd34, 0, 6'd0, 1), 1'b0);
      checkOutput("full.refuse", 1'b0, 1'b1, 3'd1, 6'd31, 4);
      nextLine = 34;
      for (int i = 0; i < 10; i++) begin
         if (bus.req_allowIn) begin
            expQ.push_back(6'(nextLine));
            applyStimulus(mkStim(1, 0, 0, 2'd0, 6'(nextLine), 0, 6'd0, 1), 1'b0);
            nextLine++;
         end else begin
            applyStimulus(idle(1), 1'b0);
         end
      end
      k = 0;
      while (k < 30 && bus.iq_occupancy != 0) begin
         applyStimulus(idle(1), 1'b0);
         k++;
      end
      checkInt("drain.occupancy", int'(bus.iq_occupancy), 0);
      checkInt("drain.count", issuedQ.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) begin
         checkInt($sformatf("drain.order%0d", i),
                  (i < issuedQ.size()) ? int'(issuedQ[i]) : -1, int'(expQ[i]));
      end

      // Reset with ready entries pending discards them.
      applyStimulus(mkStim(1, 0, 0, 2'd0, 6'd40, 0, 6'd0, 0), 1'b0);
      applyStimulus(mkStim(1, 0, 0, 2'd0, 6'd41, 0, 6'd0, 0), 1'b0);
      checkOutput("preReset", 1'b1, 1'b1, 3'd1, 6'd40, 2);
      applyStimulus(idle(1), 1'b1);
      checkOutput("midReset", 1'b1, 1'b0, 3'd0, 6'd0, 0);
      applyStimulus(idle(1), 1'b0);
      checkOutput("postReset", 1'b1, 1'b0, 3'd0, 6'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
